// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the MIPS core (port 0)
// and a debug/DMA master (port 1). Grants are same-cycle and read data is registered one cycle later.
module dmem_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,

    output logic [CW-1:0] conflict_cnt
);

    logic          ptr_reg;
    logic          ptr_next;
    logic [1:0]    gnt_vec;
    logic [1:0]    we_vec;
    logic [1:0]    rvalid_vec;
    logic [DW-1:0] rdata_vec [2];
    logic [CW-1:0] conflict_cnt_reg;
    logic [CW-1:0] conflict_cnt_next;
    logic          both_req;

    assign both_req = req0 & req1;
    assign we_vec   = {we1, we0};

    // A lone requester always wins; on contention ptr_reg names the winner.
    always_comb begin
        gnt_vec    = 2'b00;
        gnt_vec[0] = req0 & (~req1 | ~ptr_reg);
        gnt_vec[1] = req1 & (~req0 |  ptr_reg);
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (gnt_vec[0]) begin
            ptr_next = 1'b1;
        end else if (gnt_vec[1]) begin
            ptr_next = 1'b0;
        end
    end

    always_comb begin
        conflict_cnt_next = conflict_cnt_reg;
        if (both_req && (conflict_cnt_reg != {CW{1'b1}})) begin
            conflict_cnt_next = conflict_cnt_reg + CW'(1);
        end
    end

    // With no grant the port 0 inputs are forwarded; memory ignores them since mem_we is low.
    always_comb begin
        mem_a  = addr0;
        mem_wd = wdata0;
        if (gnt_vec[1]) begin
            mem_a  = addr1;
            mem_wd = wdata1;
        end
        mem_we = |(gnt_vec & we_vec);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg          <= 1'b0;
            conflict_cnt_reg <= '0;
        end else begin
            ptr_reg          <= ptr_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_port
            logic          rvalid_reg;
            logic [DW-1:0] rdata_reg;
            logic          rd_take;

            assign rd_take = gnt_vec[gi] & ~we_vec[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= rd_take;
                    if (rd_take) begin
                        rdata_reg <= mem_rd;
                    end
                end
            end

            assign rvalid_vec[gi] = rvalid_reg;
            assign rdata_vec[gi]  = rdata_reg;
        end
    endgenerate

    assign gnt0         = gnt_vec[0];
    assign gnt1         = gnt_vec[1];
    assign rvalid0      = rvalid_vec[0];
    assign rvalid1      = rvalid_vec[1];
    assign rdata0       = rdata_vec[0];
    assign rdata1       = rdata_vec[1];
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory attached.
// Inputs change 1 ns after each rising edge; outputs are checked 2 ns after it.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic [CW-1:0] conflict_cnt;

    logic [DW-1:0] ram [0:63];

    int tests_run;
    int tests_failed;

    dmem_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .gnt0         (gnt0),
        .rvalid0      (rvalid0),
        .rdata0       (rdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .gnt1         (gnt1),
        .rvalid1      (rvalid1),
        .rdata1       (rdata1),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = ram[mem_a[7:2]];

    // Memory: preload, then commit writes on each rising edge.
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        ram[5] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_gnt0",    {63'd0, gnt0},    64'd0);
        check("rst_gnt1",    {63'd0, gnt1},    64'd0);
        check("rst_rvalid0", {63'd0, rvalid0}, 64'd0);
        check("rst_rvalid1", {63'd0, rvalid1}, 64'd0);
        check("rst_rdata0",  {32'd0, rdata0},  64'd0);
        check("rst_memwe",   {63'd0, mem_we},  64'd0);
        check("rst_cnt",     {60'd0, conflict_cnt}, 64'd0);
        next_cycle();
        reset = 1'b1;

        // Single-port read of RAM[5].
        next_cycle();
        drive(1, 0, 32'h14, 0, 0, 0, 0, 0);
        check("rd_gnt0",  {63'd0, gnt0},  64'd1);
        check("rd_gnt1",  {63'd0, gnt1},  64'd0);
        check("rd_mema",  {32'd0, mem_a}, 64'h14);
        check("rd_memwe", {63'd0, mem_we}, 64'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("rd_rvalid0", {63'd0, rvalid0}, 64'd1);
        check("rd_rdata0",  {32'd0, rdata0},  64'hDEADBEEF);
        check("rd_rvalid1", {63'd0, rvalid1}, 64'd0);

        // Port 1 writes 0x20, port 0 reads it back the next cycle.
        next_cycle();
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
        check("wr_gnt1",  {63'd0, gnt1},   64'd1);
        check("wr_memwe", {63'd0, mem_we}, 64'd1);
        check("wr_memwd", {32'd0, mem_wd}, 64'h12345678);
        check("wr_rvalid0_drop", {63'd0, rvalid0}, 64'd0);
        next_cycle();
        drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
        check("raw_gnt0",    {63'd0, gnt0},    64'd1);
        check("wr_norvalid1", {63'd0, rvalid1}, 64'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("raw_rvalid0", {63'd0, rvalid0}, 64'd1);
        check("raw_rdata0",  {32'd0, rdata0},  64'h12345678);

        // Port 1 alone (ptr favours 1 now), then contention: port 0 must win.
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h14, 0);
        check("hold_rvalid0", {63'd0, rvalid0}, 64'd0);
        check("hold_rdata0",  {32'd0, rdata0},  64'h12345678);
        check("p1_gnt1",      {63'd0, gnt1},    64'd1);
        next_cycle();
        drive(1, 0, 32'h20, 0, 1, 0, 32'h14, 0);
        check("ptr_gnt0",   {63'd0, gnt0},    64'd1);
        check("ptr_gnt1",   {63'd0, gnt1},    64'd0);
        check("p1_rvalid1", {63'd0, rvalid1}, 64'd1);
        check("p1_rdata1",  {32'd0, rdata1},  64'hDEADBEEF);

        // Reset asserted while a read result is being presented.
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_rvalid0", {63'd0, rvalid0}, 64'd1);
        check("pre_rst_cnt",     {60'd0, conflict_cnt}, 64'd1);
        reset = 1'b0;
        #1;
        check("async_rvalid0", {63'd0, rvalid0}, 64'd0);
        check("async_rdata0",  {32'd0, rdata0},  64'd0);
        check("async_cnt",     {60'd0, conflict_cnt}, 64'd0);
        next_cycle();
        reset = 1'b1;

        // Contention alternation: port 0 writes, port 1 reads.
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive(1, 1, 32'h30, 32'hA5A5_0000 + c, 1, 0, 32'h14, 0);
            check($sformatf("alt%0d_gnt0", c),  {63'd0, gnt0},   (c % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("alt%0d_gnt1", c),  {63'd0, gnt1},   (c % 2 == 1) ? 64'd1 : 64'd0);
            check($sformatf("alt%0d_memwe", c), {63'd0, mem_we}, (c % 2 == 0) ? 64'd1 : 64'd0);
            if (c == 2) begin
                check("alt_rvalid1", {63'd0, rvalid1}, 64'd1);
                check("alt_rdata1",  {32'd0, rdata1},  64'hDEADBEEF);
            end
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("alt_cnt4", {60'd0, conflict_cnt}, 64'd4);

        // Saturation of the 4-bit counter.
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive(1, 1, 32'h30, 0, 1, 0, 32'h14, 0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("sat_cnt14", {60'd0, conflict_cnt}, 64'd14);
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            drive(1, 1, 32'h30, 0, 1, 0, 32'h14, 0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("sat_cnt15", {60'd0, conflict_cnt}, 64'd15);
        check("idle_gnt",  {62'd0, gnt1, gnt0},   64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
